ram_dp_responder: RTL and testbench

- Memory-side responder for the team's simple dual-port RAM interface: one write port (wr_enb/wr_addr/wr_data) and one read port (rd_enb/rd_addr/rd_data).
- Serves the accesses that the testbench driver and the system's initiators issue on that interface.
- Adds a post-reset clear sequencer, registered reads with a valid strobe, write-first collision bypass, and a busy-error indication.
- Sits directly behind the RAM interface's DUT-side view.

---
 rtl/ram_pkg.sv | 18 +
 rtl/ram_dp_responder_if.sv | 25 ++
 rtl/ram_dp_array.sv | 26 ++
 rtl/ram_dp_responder.sv | 118 +++++++++++
 tb/tb_ram_dp_responder.sv | 139 +++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared widths, depth and FSM state type for the dual-port RAM responder.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package ram_pkg;
  localparam int unsigned RAM_ADDR_WIDTH = `ADDR_WIDTH;
  localparam int unsigned RAM_DATA_WIDTH = `DATA_WIDTH;
  localparam int unsigned DEPTH          = 1 << RAM_ADDR_WIDTH;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } ram_state_e;
endpackage

// File: rtl/ram_dp_responder_if.sv
// Dual-port RAM interface: one write port, one read port, plus status strobes.
interface ram_dp_responder_if #(
  parameter int unsigned ADDR_WIDTH = ram_pkg::RAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ram_pkg::RAM_DATA_WIDTH
) ();
  logic                  wr_enb;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_enb;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  init_done;
  logic                  busy_err;

  modport master (
    output wr_enb, wr_addr, wr_data, rd_enb, rd_addr,
    input  rd_data, rd_valid, init_done, busy_err
  );

  modport slave (
    input  wr_enb, wr_addr, wr_data, rd_enb, rd_addr,
    output rd_data, rd_valid, init_done, busy_err
  );
endinterface

// File: rtl/ram_dp_array.sv
// Plain storage array: one write port, one synchronous read port, no reset.
module ram_dp_array #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  localparam int unsigned WORDS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [WORDS];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Read returns the pre-write word on a collision; the responder bypasses it.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/ram_dp_responder.sv
// Memory-side responder: post-reset clear sweep, registered reads with valid,
// write-first collision bypass and busy-error strobe.
module ram_dp_responder #(
  parameter int unsigned ADDR_WIDTH = ram_pkg::RAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ram_pkg::RAM_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic               clk,
  input logic               rst,
  ram_dp_responder_if.slave bus
);
  import ram_pkg::*;

  localparam int unsigned WORDS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);

  ram_state_e            r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_ptr, w_ptr_nxt;
  logic                  r_init_done, w_init_done_nxt;

  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_waddr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic                  w_rd_accept;
  logic                  w_collide;
  logic                  w_busy;
  logic [DATA_WIDTH-1:0] w_arr_q;

  logic                  r_rd_valid;
  logic                  r_busy_err;
  logic                  r_rd_zero;
  logic                  r_use_byp;
  logic [DATA_WIDTH-1:0] r_byp_data;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= INIT;
      r_ptr       <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_init_done <= w_init_done_nxt;
    end
  end

  // Next state, write mux (sweep vs. user), read accept and busy detect.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_init_done_nxt = r_init_done;
    w_mem_we        = 1'b0;
    w_mem_waddr     = r_ptr;
    w_mem_wdata     = INIT_VALUE;
    w_rd_accept     = 1'b0;
    w_collide       = 1'b0;
    w_busy          = 1'b0;
    if (!rst) begin
      case (r_state)
        INIT: begin
          w_mem_we  = 1'b1;
          w_ptr_nxt = r_ptr + ADDR_WIDTH'(1);
          w_busy    = bus.wr_enb | bus.rd_enb;
          if (r_ptr == LAST_ADDR) begin
            w_state_nxt     = READY;
            w_init_done_nxt = 1'b1;
          end
        end
        READY: begin
          w_mem_we    = bus.wr_enb;
          w_mem_waddr = bus.wr_addr;
          w_mem_wdata = bus.wr_data;
          w_rd_accept = bus.rd_enb;
          w_collide   = bus.rd_enb & bus.wr_enb & (bus.wr_addr == bus.rd_addr);
        end
        default: w_state_nxt = INIT;
      endcase
    end
  end

  // Read/status registers; rd_data holds between reads and reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_busy_err <= 1'b0;
      r_rd_zero  <= 1'b1;
      r_use_byp  <= 1'b0;
      r_byp_data <= '0;
    end else begin
      r_rd_valid <= w_rd_accept;
      r_busy_err <= w_busy;
      if (w_rd_accept) begin
        r_rd_zero <= 1'b0;
        r_use_byp <= w_collide;
      end
      if (w_collide) r_byp_data <= bus.wr_data;
    end
  end

  ram_dp_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_waddr),
    .i_wdata (w_mem_wdata),
    .i_re    (w_rd_accept),
    .i_raddr (bus.rd_addr),
    .o_rdata (w_arr_q)
  );

  assign bus.rd_data   = r_rd_zero ? '0 : (r_use_byp ? r_byp_data : w_arr_q);
  assign bus.rd_valid  = r_rd_valid;
  assign bus.init_done = r_init_done;
  assign bus.busy_err  = r_busy_err;
endmodule

// File: tb/tb_ram_dp_responder.sv
// Directed bench for ram_dp_responder with a behavioural memory model and read scoreboard.
module tb_ram_dp_responder;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned NW = 16;
  localparam logic [DW-1:0] INIT_VAL = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram_dp_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_dp_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .INIT_VALUE (INIT_VAL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [NW];
  logic [DW-1:0] sb [$];
  logic [DW-1:0] exp_rd = '0;
  int            init_cnt = 0;
  bit            exp_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, advance the model, then compare after the edge.
  task automatic step(input bit r, input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit re, input logic [AW-1:0] ra);
    bit ready;
    rst         = r;
    bus.wr_enb  = we;
    bus.wr_addr = we ? wa : 'x;
    bus.wr_data = we ? wd : 'x;
    bus.rd_enb  = re;
    bus.rd_addr = re ? ra : 'x;
    ready = (init_cnt >= NW);
    if (r) begin
      sb.delete();
      exp_rd   = '0;
      exp_busy = 1'b0;
      init_cnt = 0;
    end else begin
      if (!ready) begin
        model[init_cnt] = INIT_VAL;
        exp_busy = we | re;
        init_cnt++;
      end else begin
        exp_busy = 1'b0;
        if (re) sb.push_back((we && wa == ra) ? wd : model[ra]);
        if (we) model[wa] = wd;
      end
    end
    @(posedge clk);
    #1;
    chk("rd_valid", 32'(bus.rd_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) exp_rd = sb.pop_front();
    chk("rd_data", 32'(bus.rd_data), 32'(exp_rd));
    chk("busy_err", 32'(bus.busy_err), 32'(exp_busy));
    chk("init_done", 32'(bus.init_done), 32'(init_cnt >= NW));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(1'b0, 1'b1, a, d, 1'b0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b0, 1'b0, '0, '0, 1'b1, a);
  endtask

  initial begin
    bus.wr_enb = 1'b0;
    bus.rd_enb = 1'b0;
    #2;

    // Reset for two cycles, then the sweep with a dropped request on cycle 5.
    step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    for (int i = 1; i <= 16; i++) begin
      if (i == 5) step(1'b0, 1'b1, 4'd2, 8'hFF, 1'b1, 4'd2);
      else        idle();
    end
    for (int a = 0; a < 16; a++) rd(AW'(a));
    idle();

    // Write/read latency with back-to-back reads, then hold.
    wr(4'd3, 8'hA5);
    wr(4'd12, 8'h5A);
    rd(4'd3);
    rd(4'd12);
    idle();
    idle();

    // Write-first collision and independent different-address access.
    wr(4'd7, 8'h11);
    step(1'b0, 1'b1, 4'd7, 8'h99, 1'b1, 4'd7);
    rd(4'd7);
    step(1'b0, 1'b1, 4'd4, 8'h22, 1'b1, 4'd7);
    rd(4'd4);
    idle();

    // Address extremes.
    wr(4'd15, 8'hFF);
    wr(4'd0, 8'h01);
    rd(4'd15);
    rd(4'd0);
    idle();

    // Reset while a read is in flight, then re-cleared contents.
    wr(4'd9, 8'h3C);
    rd(4'd9);
    step(1'b1, 1'b0, '0, '0, 1'b1, 4'd9);
    for (int i = 0; i < 16; i++) idle();
    rd(4'd9);
    rd(4'd15);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
